// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C codec init sequencer: master register map,
// command/status bit positions and the sequencer state encoding.
`timescale 1ns/1ps
package i2c_pkg;

  // Register addresses of the i2c master's Avalon slave port
  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  // Command register bit positions
  localparam int CMD_START_BIT = 0;
  localparam int CMD_WRITE_BIT = 1;
  localparam int CMD_ACK_BIT   = 2;
  localparam int CMD_STOP_BIT  = 3;

  localparam logic [7:0] CMD_START = 8'(1 << CMD_START_BIT);
  localparam logic [7:0] CMD_WRITE = 8'(1 << CMD_WRITE_BIT);
  localparam logic [7:0] CMD_ACK   = 8'(1 << CMD_ACK_BIT);
  localparam logic [7:0] CMD_STOP  = 8'(1 << CMD_STOP_BIT);

  // Status register field positions
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_RDY_BIT  = 1;
  localparam int ST_ERR_LSB  = 2;
  localparam int ST_ERR_MSB  = 3;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    WR_DATA,
    WR_CMD,
    POLL_RD,
    POLL_CHK,
    NEXT_BYTE,
    NEXT_WORD,
    DONE,
    FAIL
  } seqState_e;

  // Command that accompanies each of the three bytes of a register write:
  // address byte opens the transaction, the last data byte closes it.
  function automatic logic [7:0] cmdForByte(input logic [1:0] byteCnt);
    logic [7:0] cmd;
    case (byteCnt)
      2'd0:    cmd = CMD_START | CMD_WRITE;
      2'd1:    cmd = CMD_WRITE;
      default: cmd = CMD_WRITE | CMD_STOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_init_sequencer.sv
// Walks an external table of codec configuration words and writes each one
// over I2C through an Avalon-attached i2c master, retrying NACKed words.
`timescale 1ns/1ps
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADR   = 7'h1A,
  parameter int         N_REGS    = 11,
  parameter int         MAX_RETRY = 3,
  localparam int        IdxW      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [IdxW-1:0] tblAdr,
  input  logic [15:0]     tblData,
  output logic [1:0]      avmAdr,
  output logic            avmWr,
  output logic [7:0]      avmWrData,
  output logic            avmRd,
  input  logic [7:0]      avmRdData
);

  localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(N_REGS - 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);

  seqState_e         state;
  logic [IdxW-1:0]   idx;
  logic [RetryW-1:0] retryCnt;
  logic [1:0]        byteCnt;
  logic [15:0]       word;
  logic              stopping;
  logic              giveUp;

  logic [1:0] statusErr;
  logic       unusedStatus;

  assign statusErr    = avmRdData[ST_ERR_MSB:ST_ERR_LSB];
  assign unusedStatus = ^{avmRdData[7:4], avmRdData[ST_RDY_BIT]};

  // Byte sent on the bus for a given position within the current word
  function automatic logic [7:0] byteFor(input logic [1:0] pos, input logic [15:0] w);
    logic [7:0] b;
    case (pos)
      2'd0:    b = {DEV_ADR, 1'b0};
      2'd1:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Sequencer FSM; bus strobes are set on entry so they coincide with their state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      tblAdr    <= '0;
      avmAdr    <= '0;
      avmWr     <= 1'b0;
      avmWrData <= '0;
      avmRd     <= 1'b0;
      idx       <= '0;
      retryCnt  <= '0;
      byteCnt   <= '0;
      word      <= '0;
      stopping  <= 1'b0;
      giveUp    <= 1'b0;
    end else begin
      avmWr <= 1'b0;
      avmRd <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            fail     <= 1'b0;
            idx      <= '0;
            retryCnt <= '0;
            tblAdr   <= '0;
            stopping <= 1'b0;
            giveUp   <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          word      <= tblData;
          byteCnt   <= 2'd0;
          avmWr     <= 1'b1;
          avmAdr    <= REG_TX;
          avmWrData <= byteFor(2'd0, tblData);
          state     <= WR_DATA;
        end
        WR_DATA: begin
          avmWr     <= 1'b1;
          avmAdr    <= REG_CMD;
          avmWrData <= cmdForByte(byteCnt);
          state     <= WR_CMD;
        end
        WR_CMD: begin
          if (giveUp) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end else begin
            avmRd  <= 1'b1;
            avmAdr <= REG_STATUS;
            state  <= POLL_RD;
          end
        end
        POLL_RD: state <= POLL_CHK;
        POLL_CHK: begin
          if (avmRdData[ST_BUSY_BIT]) begin
            avmRd  <= 1'b1;
            avmAdr <= REG_STATUS;
            state  <= POLL_RD;
          end else if (stopping) begin
            stopping <= 1'b0;
            tblAdr   <= idx;
            state    <= FETCH;
          end else if (statusErr != 2'b00) begin
            avmWr     <= 1'b1;
            avmAdr    <= REG_CMD;
            avmWrData <= CMD_STOP;
            if (retryCnt < MaxRetry) begin
              retryCnt <= retryCnt + RetryW'(1);
              stopping <= 1'b1;
            end else begin
              giveUp <= 1'b1;
            end
            state <= WR_CMD;
          end else begin
            state <= NEXT_BYTE;
          end
        end
        NEXT_BYTE: begin
          if (byteCnt == 2'd2) begin
            state <= NEXT_WORD;
          end else begin
            byteCnt   <= byteCnt + 2'd1;
            avmWr     <= 1'b1;
            avmAdr    <= REG_TX;
            avmWrData <= byteFor(byteCnt + 2'd1, word);
            state     <= WR_DATA;
          end
        end
        NEXT_WORD: begin
          retryCnt <= '0;
          if (idx == LastIdx) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx    <= idx + IdxW'(1);
            tblAdr <= idx + IdxW'(1);
            state  <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADR, default 7'h1A, the 7-bit I2C slave address of the codec.
REQ-002 SHALL have parameter N_REGS, default 11, the number of configuration words in the table (range 1..256).
REQ-003 SHALL have parameter MAX_RETRY, default 3, the number of re-attempts per word after a NACK error.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to run the whole table.
REQ-007 SHALL have port busy, output, 1 bit: high while a sequence runs.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the sequence succeeds.
REQ-009 SHALL have port fail, output, 1 bit: level, set on abort and cleared by the next start.
REQ-010 SHALL have port tblAdr, output, $clog2(N_REGS) bits (minimum 1): configuration table index.
REQ-011 SHALL have port tblData, input, 16 bits: table word {regAdr[6:0], regVal[8:0]}, valid 1 cycle after tblAdr.
REQ-012 SHALL have port avmAdr, output, 2 bits: master-side Avalon address toward the i2c master.
REQ-013 SHALL have port avmWr, output, 1 bit: Avalon write strobe.
REQ-014 SHALL have port avmWrData, output, 8 bits: Avalon write data.
REQ-015 SHALL have port avmRd, output, 1 bit: Avalon read strobe.
REQ-016 SHALL have port avmRdData, input, 8 bits: Avalon read data, valid 1 cycle after avmRd.

Function
REQ-017 SHALL use this i2c master register map: adr 0 = TX byte (write); adr 1 = command (write; bit0 start, bit1 write, bit2 ack, bit3 stop; the write launches the command); adr 2 = status (read; bit0 busy, bit1 rdy, bits3:2 err, 00 = OK).
REQ-018 SHALL run the FSM states IDLE, FETCH, LOAD, WR_DATA, WR_CMD, POLL_RD, POLL_CHK, NEXT_BYTE, NEXT_WORD, DONE, FAIL.
REQ-019 IDLE: on start, SHALL set busy, clear fail, zero the index and retry counter, and go to FETCH.
REQ-020 FETCH: SHALL drive tblAdr = index; LOAD SHALL capture tblData and set byte counter = 0.
REQ-021 SHALL send per word three bytes in order: {DEV_ADR,1'b0} with cmd start|write; {regAdr,regVal[8]} with cmd write; regVal[7:0] with cmd write|stop.
REQ-022 WR_DATA SHALL issue exactly one avmWr at adr 0; WR_CMD SHALL issue exactly one avmWr at adr 1 on the next cycle.
REQ-023 POLL_RD SHALL issue a one-cycle avmRd at adr 2; POLL_CHK SHALL sample avmRdData on the following cycle.
REQ-024 In POLL_CHK, busy=1 SHALL return to POLL_RD; busy=0 with err=00 SHALL go to NEXT_BYTE.
REQ-025 In POLL_CHK, busy=0 with err!=00 SHALL, while retries < MAX_RETRY, increment the retry counter, write cmd stop (adr 1, 0x08), wait for not-busy, and restart the current word at byte 0.
REQ-026 Once the retries are exhausted, an error SHALL write cmd stop and go to FAIL.
REQ-027 After byte 2, NEXT_WORD SHALL clear the retry counter and increment the index, going to DONE when index = N_REGS-1, else to FETCH.
REQ-028 DONE SHALL pulse done for 1 cycle, drop busy, and go to IDLE; FAIL SHALL set fail, drop busy, and go to IDLE.
REQ-029 At most one of avmWr and avmRd SHALL be high in any cycle; all strobes SHALL be single-cycle.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 On reset low at a clk edge, the FSM SHALL enter IDLE and busy, done, fail, avmWr, avmRd, avmAdr, avmWrData, tblAdr SHALL be 0, including mid-transfer; no stop command is issued.

Structure
REQ-032 A shared package i2c_pkg SHALL hold the register addresses, command bit positions, status field positions, and the FSM state enum.
REQ-033 There SHALL be no sub-modules; the table ROM SHALL be external.

Verification
REQ-034 SHALL cover nominal operation: N_REGS=2 with a slave model that always ACKs; start -> 6 byte transfers, bytes 0x34,(w0>>8),(w0&FF),0x34,…; done pulses once; fail=0.
REQ-035 SHALL cover a single NACK: the status model returns err=01 on byte 1 of word 0 once -> a stop is written, word 0 resends from byte 0, done pulses.
REQ-036 SHALL cover persistent NACK with MAX_RETRY=3: 4 attempts of word 0, then fail=1, busy=0, no done.
REQ-037 SHALL cover busy polling: status busy held 5 reads -> exactly 6 avmRd pulses for that byte, then the sequence proceeds.
REQ-038 SHALL cover reset mid-byte: reset low during POLL_RD -> the next cycle has all outputs 0 and state IDLE; a new start runs from index 0.
REQ-039 SHALL cover start while busy: pulse start at word 1 -> no restart and the index continues.
